// File: rtl/app_instr_sender_pkg.sv
// rtl/app_instr_sender_pkg.sv - softMC instruction fields and sender FSM encoding
package app_instr_sender_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;

  // Matches END_ISEQ in softMC.inc
  localparam logic [3:0] END_ISEQ = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_ERROR
  } sender_state_t;

  function automatic logic is_end_iseq(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == END_ISEQ;
  endfunction

endpackage

// File: rtl/app_instr_sender_instr_stage_fifo.sv
// rtl/app_instr_sender_instr_stage_fifo.sv - first-word-fall-through staging FIFO for host instruction words
module instr_stage_fifo
  import app_instr_sender_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       wr_data,
  input  logic                     pop,
  output logic [INSTR_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/app_instr_sender.sv
// rtl/app_instr_sender.sv - stages host instruction words and hands them to softMC one at a time
module app_instr_sender
  import app_instr_sender_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_instr,
  output logic                 app_en,
  output logic [31:0]          app_instr,
  input  logic                 app_ack,
  input  logic                 iq_full,
  input  logic                 processing_iseq,
  output logic                 busy,
  output logic                 iseq_done,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 ack_err,
  input  logic                 clear
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  sender_state_t             state, state_n;
  logic                      rdy_en;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0]               fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [TW-1:0]             ack_timer, ack_timer_n;
  logic                      app_en_n, iseq_done_n, ack_err_n;
  logic [31:0]               app_instr_n;
  logic [CNT_WIDTH-1:0]      count_n;

  // rdy_en keeps s_ready low while rst is held and for the reset edge itself
  assign s_ready   = rdy_en && !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  instr_stage_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (s_instr),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_n     = state;
    app_en_n    = app_en;
    app_instr_n = app_instr;
    count_n     = instr_count;
    iseq_done_n = 1'b0;
    ack_err_n   = ack_err;
    ack_timer_n = ack_timer;
    fifo_pop    = 1'b0;
    if (clear) begin
      state_n     = ST_IDLE;
      app_en_n    = 1'b0;
      count_n     = '0;
      ack_err_n   = 1'b0;
      ack_timer_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !iq_full) begin
            fifo_pop    = 1'b1;
            app_instr_n = fifo_data;
            app_en_n    = 1'b1;
            ack_timer_n = '0;
            state_n     = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // An ack on the final allowed cycle still beats the timeout
          if (app_ack) begin
            app_en_n = 1'b0;
            count_n  = instr_count + CNT_WIDTH'(1);
            state_n  = is_end_iseq(app_instr) ? ST_WAIT_START : ST_IDLE;
          end else if (ack_timer == TW'(ACK_TIMEOUT - 1)) begin
            app_en_n  = 1'b0;
            ack_err_n = 1'b1;
            state_n   = ST_ERROR;
          end else begin
            ack_timer_n = ack_timer + TW'(1);
          end
        end
        ST_WAIT_START: begin
          if (processing_iseq) state_n = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!processing_iseq) begin
            iseq_done_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end
        ST_ERROR: begin
          app_en_n  = 1'b0;
          ack_err_n = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rdy_en      <= 1'b0;
      app_en      <= 1'b0;
      app_instr   <= '0;
      instr_count <= '0;
      iseq_done   <= 1'b0;
      ack_err     <= 1'b0;
      ack_timer   <= '0;
    end else begin
      state       <= state_n;
      rdy_en      <= 1'b1;
      app_en      <= app_en_n;
      app_instr   <= app_instr_n;
      instr_count <= count_n;
      iseq_done   <= iseq_done_n;
      ack_err     <= ack_err_n;
      ack_timer   <= ack_timer_n;
    end
  end

endmodule

// File: tb/tb_app_instr_sender.sv
// tb/tb_app_instr_sender.sv - randomized self-checking bench for app_instr_sender
module tb_app_instr_sender;

  localparam int FIFO_DEPTH  = 16;
  localparam int ACK_TIMEOUT = 1024;
  localparam int CNT_WIDTH   = 16;
  localparam logic [3:0] OP_END = 4'h0;

  logic                 clk;
  logic                 rst, s_valid, s_ready, app_en, app_ack, iq_full;
  logic                 processing_iseq, busy, iseq_done, ack_err, clear;
  logic [31:0]          s_instr, app_instr;
  logic [CNT_WIDTH-1:0] instr_count;

  int checks = 0;
  int failures = 0;
  logic [31:0]          exp_q[$];
  logic [CNT_WIDTH-1:0] model_count;

  app_instr_sender #(
    .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_instr(s_instr),
    .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack), .iq_full(iq_full),
    .processing_iseq(processing_iseq), .busy(busy), .iseq_done(iseq_done),
    .instr_count(instr_count), .ack_err(ack_err), .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word(input logic [3:0] op);
    logic [31:0] w;
    w = $urandom;
    w[31:28] = op;
    return w;
  endfunction

  // Acks every issued word and consumes exp_q in order; reports order errors and time-out
  task automatic drain(input int max_cycles, output int bad, output bit timed_out);
    bit en_b, ack_b;
    logic [31:0] exp_w;
    bad = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_q.size() == 0 && !app_en) begin timed_out = 1'b0; break; end
      app_ack = app_en;
      en_b = app_en; ack_b = app_ack;
      step();
      if (en_b && ack_b) model_count++;
      if (app_en && !en_b) begin
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 32'hxxxxxxxx;
        if (app_instr !== exp_w) bad++;
      end
    end
    app_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_instr = '0; app_ack = 1'b0; iq_full = 1'b0;
    processing_iseq = 1'b0; clear = 1'b0;
    repeat (3) step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready_during_rst got=%b exp=0", s_ready); end
    checks++; if ({app_en, busy, iseq_done, ack_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {app_en, busy, iseq_done, ack_err}); end
    checks++; if (app_instr !== 32'h0) begin failures++; $display("FAIL reset_app_instr got=%h exp=0", app_instr); end
    checks++; if (instr_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    rst = 1'b0;
    step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready_after got=%b exp=1", s_ready); end
    checks++; if ({app_en, busy} !== 2'b00) begin failures++; $display("FAIL reset_idle_after got=%b exp=00", {app_en, busy}); end
    model_count = '0;
    exp_q.delete();
  endtask

  task automatic test_three_words();
    int pushed = 0, windows = 0, en_age = 0, low_run = 0;
    bit en_b, ack_b, acc;
    logic [31:0] held, exp_w;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      s_valid = (pushed < 3);
      s_instr = rand_word(4'h1);
      app_ack = app_en && (en_age == 2);
      acc = s_valid && s_ready; en_b = app_en; ack_b = app_ack;
      step();
      if (acc) begin exp_q.push_back(s_instr); pushed++; end
      if (en_b && ack_b) model_count++;
      checks++; if (instr_count !== model_count) begin failures++; $display("FAIL three_count got=%0d exp=%0d", instr_count, model_count); end
      if (app_en && !en_b) begin
        windows++; en_age = 1; held = app_instr;
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 32'hxxxxxxxx;
        checks++; if (app_instr !== exp_w) begin failures++; $display("FAIL three_order got=%h exp=%h", app_instr, exp_w); end
        if (windows > 1) begin
          checks++; if (low_run !== 1) begin failures++; $display("FAIL three_gap got=%0d exp=1", low_run); end
        end
      end else if (app_en) begin
        en_age++;
        checks++; if (app_instr !== held) begin failures++; $display("FAIL three_stable got=%h exp=%h", app_instr, held); end
      end else begin
        low_run = en_b ? 1 : low_run + 1;
        en_age = 0;
      end
    end
    s_valid = 1'b0; app_ack = 1'b0;
    checks++; if (windows !== 3) begin failures++; $display("FAIL three_windows got=%0d exp=3", windows); end
    checks++; if (instr_count !== 16'd3) begin failures++; $display("FAIL three_final_count got=%0d exp=3", instr_count); end
  endtask

  task automatic test_end_iseq();
    logic [31:0] w_end, w_nxt;
    bit got = 1'b0;
    w_end = rand_word(OP_END);
    w_nxt = rand_word(4'h1);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL end_ready got=%b exp=1", s_ready); end
    s_valid = 1'b1; s_instr = w_end; step(); s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (app_en) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got || app_instr !== w_end) begin failures++; $display("FAIL end_issue got=%h exp=%h", app_instr, w_end); end
    app_ack = 1'b1; step(); app_ack = 1'b0; model_count++;
    checks++; if (app_en !== 1'b0 || instr_count !== model_count) begin failures++; $display("FAIL end_ack got=%b/%0d exp=0/%0d", app_en, instr_count, model_count); end
    s_valid = 1'b1; s_instr = w_nxt; step(); s_valid = 1'b0;
    processing_iseq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if ({app_en, iseq_done, busy} !== 3'b001) begin failures++; $display("FAIL end_hold got=%b exp=001", {app_en, iseq_done, busy}); end
    end
    processing_iseq = 1'b0;
    step();
    checks++; if ({iseq_done, app_en} !== 2'b10) begin failures++; $display("FAIL end_done_pulse got=%b exp=10", {iseq_done, app_en}); end
    step();
    checks++; if ({iseq_done, app_en} !== 2'b01 || app_instr !== w_nxt) begin failures++; $display("FAIL end_next_issue got=%b/%h exp=01/%h", {iseq_done, app_en}, app_instr, w_nxt); end
    app_ack = 1'b1; step(); app_ack = 1'b0; model_count++;
    checks++; if (instr_count !== model_count) begin failures++; $display("FAIL end_count got=%0d exp=%0d", instr_count, model_count); end
  endtask

  task automatic test_iq_full();
    logic [31:0] w0, w1;
    w0 = rand_word(4'h1);
    w1 = rand_word(4'h2);
    iq_full = 1'b1;
    s_valid = 1'b1; s_instr = w0; step(); s_instr = w1; step(); s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL iqf_hold got=%b exp=0", app_en); end
    end
    iq_full = 1'b0;
    step();
    checks++; if (app_en !== 1'b1 || app_instr !== w0) begin failures++; $display("FAIL iqf_resume got=%b/%h exp=1/%h", app_en, app_instr, w0); end
    app_ack = 1'b1; step(); app_ack = 1'b0; model_count++;
    step();
    checks++; if (app_en !== 1'b1 || app_instr !== w1) begin failures++; $display("FAIL iqf_second got=%b/%h exp=1/%h", app_en, app_instr, w1); end
    iq_full = 1'b1;
    repeat (3) step();
    checks++; if (app_en !== 1'b1) begin failures++; $display("FAIL iqf_no_drop got=%b exp=1", app_en); end
    app_ack = 1'b1; step(); app_ack = 1'b0; model_count++; iq_full = 1'b0;
    checks++; if (instr_count !== model_count) begin failures++; $display("FAIL iqf_count got=%0d exp=%0d", instr_count, model_count); end
  endtask

  task automatic test_random_stream(input int n_words);
    int pushed = 0, en_age = 0, ack_at = 1, ps_phase = 0, ps_wait = 0, c;
    bit en_b, ack_b, acc, seq_open = 1'b0, exp_done;
    logic [31:0] held, exp_w;
    held = '0;
    for (c = 0; c < 6000; c++) begin
      if (pushed >= n_words && exp_q.size() == 0 && !app_en && !seq_open) break;
      s_valid = (pushed < n_words) && ($urandom_range(0, 3) != 0);
      s_instr = rand_word(($urandom_range(0, 5) == 0) ? OP_END : 4'($urandom_range(1, 15)));
      iq_full = ($urandom_range(0, 4) == 0);
      app_ack = app_en ? (en_age == ack_at) : ($urandom_range(0, 7) == 0);
      exp_done = 1'b0;
      if (ps_phase == 1) begin
        if (ps_wait == 0) begin processing_iseq = 1'b1; ps_phase = 2; ps_wait = $urandom_range(1, 6); end
        else ps_wait--;
      end else if (ps_phase == 2) begin
        if (ps_wait == 0) begin processing_iseq = 1'b0; ps_phase = 3; exp_done = 1'b1; end
        else ps_wait--;
      end
      acc = s_valid && s_ready; en_b = app_en; ack_b = app_ack;
      step();
      if (acc) begin exp_q.push_back(s_instr); pushed++; end
      if (en_b && ack_b) begin
        model_count++;
        if (held[31:28] == OP_END) begin seq_open = 1'b1; ps_phase = 1; ps_wait = $urandom_range(0, 4); end
      end
      checks++; if (instr_count !== model_count) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", instr_count, model_count); end
      checks++; if (iseq_done !== exp_done) begin failures++; $display("FAIL rnd_iseq_done got=%b exp=%b", iseq_done, exp_done); end
      if (exp_done) begin seq_open = 1'b0; ps_phase = 0; end
      checks++; if (en_b && !ack_b && !app_en) begin failures++; $display("FAIL rnd_en_dropped got=0 exp=1"); end
      if (app_en && !en_b) begin
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 32'hxxxxxxxx;
        checks++; if (seq_open || app_instr !== exp_w) begin failures++; $display("FAIL rnd_issue got=%h exp=%h seq_open=%b", app_instr, exp_w, seq_open); end
        held = app_instr; en_age = 1; ack_at = $urandom_range(1, 5);
      end else if (app_en) begin
        en_age++;
        checks++; if (app_instr !== held) begin failures++; $display("FAIL rnd_stable got=%h exp=%h", app_instr, held); end
      end else begin
        en_age = 0;
      end
    end
    s_valid = 1'b0; app_ack = 1'b0; iq_full = 1'b0; processing_iseq = 1'b0;
    checks++; if (c >= 6000) begin failures++; $display("FAIL rnd_timeout got=%0d exp=<6000", c); end
    step();
    checks++; if (busy !== 1'b0 || instr_count !== model_count) begin failures++; $display("FAIL rnd_end got=%b/%0d exp=0/%0d", busy, instr_count, model_count); end
  endtask

  task automatic test_clear_ack();
    logic [31:0] w0, w1;
    bit got = 1'b0, to;
    int bad;
    w0 = rand_word(4'h3);
    w1 = rand_word(4'h4);
    s_valid = 1'b1; s_instr = w0; step(); s_instr = w1; step(); s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (app_en) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got || app_instr !== w0) begin failures++; $display("FAIL clr_issue got=%h exp=%h", app_instr, w0); end
    app_ack = 1'b1; clear = 1'b1; step(); app_ack = 1'b0; clear = 1'b0; model_count = '0;
    checks++; if (instr_count !== '0 || app_en !== 1'b0 || ack_err !== 1'b0) begin failures++; $display("FAIL clr_wins got=%0d/%b/%b exp=0/0/0", instr_count, app_en, ack_err); end
    exp_q.push_back(w1);
    drain(50, bad, to);
    checks++; if (bad != 0 || to) begin failures++; $display("FAIL clr_keep_fifo got=bad%0d/to%b exp=bad0/to0", bad, to); end
    checks++; if (instr_count !== 16'd1) begin failures++; $display("FAIL clr_count got=%0d exp=1", instr_count); end
  endtask

  task automatic test_fill();
    int accepted = 0;
    bit acc;
    logic [31:0] exp_w;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_instr = rand_word(4'h1);
      acc = s_ready;
      step();
      if (acc) begin accepted++; exp_q.push_back(s_instr); end
    end
    s_valid = 1'b0;
    checks++; if (accepted !== FIFO_DEPTH + 1) begin failures++; $display("FAIL fill_accepted got=%0d exp=%0d", accepted, FIFO_DEPTH + 1); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
    exp_w = exp_q.pop_front();
    checks++; if (app_en !== 1'b1 || app_instr !== exp_w || busy !== 1'b1) begin failures++; $display("FAIL fill_head got=%b/%h exp=1/%h", app_en, app_instr, exp_w); end
  endtask

  task automatic test_timeout();
    int hi = 1, bad;
    bit to, seen = 1'b0;
    logic [31:0] exp_w;
    app_ack = 1'b1; step(); app_ack = 1'b0; model_count++;
    step();
    exp_w = exp_q.pop_front();
    checks++; if (app_en !== 1'b1 || app_instr !== exp_w) begin failures++; $display("FAIL to_issue got=%b/%h exp=1/%h", app_en, app_instr, exp_w); end
    for (int i = 0; i < 1200; i++) begin
      step();
      if (ack_err) begin seen = 1'b1; break; end
      if (app_en) hi++;
    end
    checks++; if (!seen || hi !== ACK_TIMEOUT) begin failures++; $display("FAIL to_window got=%0d seen=%b exp=%0d", hi, seen, ACK_TIMEOUT); end
    checks++; if (app_en !== 1'b0 || instr_count !== model_count) begin failures++; $display("FAIL to_state got=%b/%0d exp=0/%0d", app_en, instr_count, model_count); end
    app_ack = 1'b1; step(); app_ack = 1'b0;
    checks++; if (instr_count !== model_count || app_en !== 1'b0) begin failures++; $display("FAIL to_stray_ack got=%0d/%b exp=%0d/0", instr_count, app_en, model_count); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL to_accept got=%b exp=1", s_ready); end
    s_valid = 1'b1; s_instr = rand_word(4'h5); step(); s_valid = 1'b0;
    exp_q.push_back(s_instr);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL to_full got=%b exp=0", s_ready); end
    repeat (5) step();
    checks++; if ({app_en, ack_err} !== 2'b01) begin failures++; $display("FAIL to_sticky got=%b exp=01", {app_en, ack_err}); end
    clear = 1'b1; step(); clear = 1'b0; model_count = '0;
    checks++; if (ack_err !== 1'b0 || instr_count !== '0 || app_en !== 1'b0) begin failures++; $display("FAIL to_clear got=%b/%0d/%b exp=0/0/0", ack_err, instr_count, app_en); end
    drain(200, bad, to);
    checks++; if (bad != 0 || to) begin failures++; $display("FAIL to_reissue got=bad%0d/to%b exp=bad0/to0", bad, to); end
    checks++; if (instr_count !== 16'(FIFO_DEPTH)) begin failures++; $display("FAIL to_reissue_count got=%0d exp=%0d", instr_count, FIFO_DEPTH); end
  endtask

  task automatic test_rst_mid();
    bit got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_instr = rand_word(4'h6); step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (app_en) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin failures++; $display("FAIL rst_mid_issue got=0 exp=1"); end
    rst = 1'b1; step();
    checks++; if ({app_en, busy, s_ready} !== 3'b000 || instr_count !== '0) begin failures++; $display("FAIL rst_mid_state got=%b/%0d exp=000/0", {app_en, busy, s_ready}, instr_count); end
    rst = 1'b0; exp_q.delete(); model_count = '0;
    step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", s_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({app_en, busy} !== 2'b00) begin failures++; $display("FAIL rst_mid_flushed got=%b exp=00", {app_en, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_end_iseq();
    test_iq_full();
    test_random_stream(60);
    test_clear_ack();
    test_fill();
    test_timeout();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
